digital_clock_ctrl: RTL
=======================

# digital_clock_ctrl

Controller that sequences the mm:ss clock counter. Generates the one-second count enable from `clk` and runs a button-driven set-time FSM. In set mode it edits shadow copies of minutes and seconds, then commits them to the counter with a one-cycle load strobe. It sits between the front-panel button pulses and the seconds/minutes counter, which takes `tick_en`, `load_en`, `load_min` and `load_sec` from this block.

## Interface
- `TICK_DIV`, default 100_000_000: `clk` cycles per tick (≥ 2).
- `TIMEOUT_TICKS`, default 10: ticks of button inactivity in set mode before the edit is abandoned (≥ 1).
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  synchronous, active-high.
- `mode_btn`  in  1  single-cycle pulse: enter set mode, advance the field, commit.
- `inc_btn`  in  1  single-cycle pulse: increment the selected field.
- `dec_btn`  in  1  single-cycle pulse: decrement the selected field.
- `cur_min`  in  6  live minutes from the counter, 0..59.
- `cur_sec`  in  6  live seconds from the counter, 0..59.
- `tick_en`  out  1  one-cycle count enable to the counter.
- `load_en`  out  1  one-cycle strobe; the counter loads `load_min`/`load_sec`.
- `load_min`  out  6  shadow minutes.
- `load_sec`  out  6  shadow seconds.
- `setting`  out  1  high in SET_MIN and SET_SEC.
- `field_sel`  out  1  0 = minutes, 1 = seconds; valid while `setting` is high.
- `blink`  out  1  display blink for the selected field.

## Operation
**Prescaler**
- Counter `pcnt` runs 0..TICK_DIV-1 and wraps. It runs in every state.
- The internal tick `t` is high for the cycle in which `pcnt == TICK_DIV-1`.

**Tick output**
- `tick_en` = `t` registered, gated to state RUN at the time `t` is high.

**FSM states:** RUN, SET_MIN, SET_SEC, COMMIT.
- RUN + `mode_btn` → SET_MIN. Shadow registers capture `cur_min` and `cur_sec` in the same cycle.
- SET_MIN + `mode_btn` → SET_SEC.
- SET_SEC + `mode_btn` → COMMIT.
- COMMIT → RUN unconditionally. `load_en` = 1 only in COMMIT.
- SET_MIN or SET_SEC, with the inactivity counter reaching TIMEOUT_TICKS → RUN. No load occurs; the shadow contents are discarded.

**Editing** (SET_MIN edits minutes, SET_SEC edits seconds)
- `inc_btn`: 59 → 0 wrap, otherwise +1.
- `dec_btn`: 0 → 59 wrap, otherwise −1.
- `inc_btn` and `dec_btn` in the same cycle: no change. This still counts as activity.
- `mode_btn` together with `inc_btn` or `dec_btn`: `mode_btn` wins and the edit is ignored.
- Button pulses are ignored in RUN, except `mode_btn`, and in COMMIT.

**Inactivity counter**
- Cleared on entry to SET_MIN and on any button pulse in SET_MIN or SET_SEC.
- Increments on `t` while in SET_MIN or SET_SEC.

**Blink**
- `blink` = 1 in RUN and COMMIT.
- In set states, `blink` = (`pcnt` < TICK_DIV/2), integer division.

**Widths and limits**
- Shadow arithmetic is 6-bit.
- `cur_*` values > 59 are clamped to 59 on capture.

## Timing
**Reset values:** state RUN, `pcnt` = 0, `tick_en` = 0, `load_en` = 0, `load_min` = 0, `load_sec` = 0, `setting` = 0, `field_sel` = 0, `blink` = 1, inactivity counter = 0.

**Latency**
- First `tick_en` occurs TICK_DIV cycles after `reset` deasserts, i.e. the cycle after `pcnt` first reaches TICK_DIV-1. Afterwards, period is TICK_DIV.
- Button pulse at edge N → state and shadow update visible at N+1.
- Third `mode_btn` at N → `load_en` high during N+1 with final shadow values, state RUN at N+2.

**Tick suppression**
- No `tick_en` in SET_MIN, SET_SEC or COMMIT. Suppressed ticks are dropped, not queued.
- `load_en` and `tick_en` are never high in the same cycle.

**Other boundaries**
- `reset` mid-edit: returns to RUN next cycle, no `load_en`, shadow values lost.
- Timeout and `mode_btn` in the same cycle: `mode_btn` wins and clears the inactivity counter.

## Structure
**Package `digital_clock_pkg`**
- `ctrl_state_t` enum.
- `MAX_SEC_MIN` = 6'd59.
- `TIME_W` = 6.
- Shared with the counter block.

**Sub-module `tick_prescaler`**
- Parameter TICK_DIV; ports `clk`, `reset`, `pcnt`, `t`.
- Reused by other timebase users.

The FSM, shadow registers and blink logic live in `digital_clock_ctrl`.

## Test plan
Run with TICK_DIV = 4 and TIMEOUT_TICKS = 3.
- Reset release, idle 20 cycles → `tick_en` pulses exactly every 4 cycles, first pulse 4 cycles after `reset` deasserts; `blink` = 1, `setting` = 0.
- `cur_min` = 12, `cur_sec` = 34; `mode_btn`, 3× `inc_btn`, `mode_btn`, 1× `dec_btn`, `mode_btn` → single `load_en` with `load_min` = 15, `load_sec` = 33; no `tick_en` from the first `mode_btn` until RUN.
- Shadow minutes = 59 + `inc_btn` → 0; shadow seconds = 0 + `dec_btn` → 59; `inc_btn` and `dec_btn` together → unchanged.
- Enter SET_MIN, no buttons for 3 ticks → returns to RUN, `load_en` never asserted, `tick_en` resumes.
- `reset` asserted while in SET_SEC → RUN next cycle, all outputs at reset values, no `load_en`.
- `mode_btn` + `inc_btn` in the same cycle in SET_MIN → state SET_SEC, minutes unchanged; `blink` toggles with period 4 in set states.

Source files
------------

// File: rtl/digital_clock_pkg.sv
// Shared types and helpers for the mm:ss clock: controller state encoding,
// time-field width and the wrap/clamp arithmetic used on minutes/seconds.
package digital_clock_pkg;

  localparam int TIME_W = 6;
  localparam logic [TIME_W-1:0] MAX_SEC_MIN = 6'd59;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_SEC = 2'd2,
    COMMIT  = 2'd3
  } ctrl_state_t;

  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v);
    return (v > MAX_SEC_MIN) ? MAX_SEC_MIN : v;
  endfunction

  function automatic logic [TIME_W-1:0] inc_wrap(input logic [TIME_W-1:0] v);
    return (v >= MAX_SEC_MIN) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [TIME_W-1:0] dec_wrap(input logic [TIME_W-1:0] v);
    return (v == '0) ? MAX_SEC_MIN : v - 1'b1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-TICK_DIV counter with a one-cycle terminal-count flag.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000,
  parameter int PCNT_W   = $clog2(TICK_DIV)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PCNT_W-1:0] pcnt,
  output logic              t
);

  localparam logic [PCNT_W-1:0] LAST = PCNT_W'(TICK_DIV - 1);

  always_ff @(posedge clk) begin
    if (reset)
      pcnt <= '0;
    else if (pcnt == LAST)
      pcnt <= '0;
    else
      pcnt <= pcnt + 1'b1;
  end

  assign t = (pcnt == LAST);

endmodule

// File: rtl/digital_clock_ctrl.sv
// Sequencer for the mm:ss counter: one-second count enable plus the
// button-driven set-time FSM that edits shadow time and commits it with a load strobe.
module digital_clock_ctrl
  import digital_clock_pkg::*;
#(
  parameter int TICK_DIV      = 100_000_000,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              inc_btn,
  input  logic              dec_btn,
  input  logic [TIME_W-1:0] cur_min,
  input  logic [TIME_W-1:0] cur_sec,
  output logic              tick_en,
  output logic              load_en,
  output logic [TIME_W-1:0] load_min,
  output logic [TIME_W-1:0] load_sec,
  output logic              setting,
  output logic              field_sel,
  output logic              blink
);

  localparam int PCNT_W = $clog2(TICK_DIV);
  localparam int ICNT_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [PCNT_W-1:0] HALF    = PCNT_W'(TICK_DIV / 2);
  localparam logic [ICNT_W-1:0] ICNT_TO = ICNT_W'(TIMEOUT_TICKS);

  ctrl_state_t state, state_next;
  logic [PCNT_W-1:0] pcnt;
  logic              t;
  logic [ICNT_W-1:0] icnt;
  logic [TIME_W-1:0] min_next, sec_next;
  logic              any_btn;
  logic              timed_out;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PCNT_W   (PCNT_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .pcnt  (pcnt),
    .t     (t)
  );

  assign any_btn   = mode_btn | inc_btn | dec_btn;
  assign timed_out = (icnt == ICNT_TO);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      load_min <= '0;
      load_sec <= '0;
      tick_en  <= 1'b0;
    end else begin
      state    <= state_next;
      load_min <= min_next;
      load_sec <= sec_next;
      tick_en  <= t && (state == RUN);
    end
  end

  // Inactivity counter only lives in the set states; it is zero everywhere else,
  // which also gives the clear on entry to SET_MIN.
  always_ff @(posedge clk) begin
    if (reset || !(state == SET_MIN || state == SET_SEC) || any_btn)
      icnt <= '0;
    else if (t && !timed_out)
      icnt <= icnt + 1'b1;
  end

  always_comb begin
    state_next = state;
    min_next   = load_min;
    sec_next   = load_sec;
    setting    = (state == SET_MIN) || (state == SET_SEC);
    field_sel  = (state == SET_SEC);
    load_en    = (state == COMMIT);
    blink      = setting ? (pcnt < HALF) : 1'b1;

    // mode_btn outranks edits and timeout; an inc+dec pair is activity but no edit.
    case (state)
      RUN: begin
        if (mode_btn) begin
          state_next = SET_MIN;
          min_next   = clamp_time(cur_min);
          sec_next   = clamp_time(cur_sec);
        end
      end
      SET_MIN: begin
        if (mode_btn)
          state_next = SET_SEC;
        else if (inc_btn && !dec_btn)
          min_next = inc_wrap(load_min);
        else if (dec_btn && !inc_btn)
          min_next = dec_wrap(load_min);
        else if (!any_btn && timed_out)
          state_next = RUN;
      end
      SET_SEC: begin
        if (mode_btn)
          state_next = COMMIT;
        else if (inc_btn && !dec_btn)
          sec_next = inc_wrap(load_sec);
        else if (dec_btn && !inc_btn)
          sec_next = dec_wrap(load_sec);
        else if (!any_btn && timed_out)
          state_next = RUN;
      end
      COMMIT: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

endmodule
